// File: rtl/pulse_conditioner.sv
// Conditions a bouncy count button and direction switch into single-cycle inc pulses plus a frozen direction.
// Latency: DEBOUNCE_CYCLES+2 edges from first raw sample to inc; no backpressure, inc is a fire-and-forget pulse.

module pulse_conditioner_db #(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [15:0] LIMIT = 16'(CYCLES - 1);

  logic [1:0]  sync;
  logic [15:0] db_cnt;

  // sync[1] is the synchronised sample; the level only moves after LIMIT+1 disagreeing samples in a row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        db_cnt <= '0;
      end else if (db_cnt == LIMIT) begin
        level  <= sync[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

endmodule

module pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned REPEAT_DELAY    = 5000,
  parameter int unsigned REPEAT_PERIOD   = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic dir_raw,
  input  logic repeat_en,
  output logic inc,
  output logic up_down_sel,
  output logic btn_db
);

  localparam logic [15:0] DELAY_LIM  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_LIM = 16'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic        inc_nxt;
  logic        uds_nxt;
  logic        dir_db;

  pulse_conditioner_db #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_raw),
    .level (btn_db)
  );

  pulse_conditioner_db #(.CYCLES(DEBOUNCE_CYCLES)) u_dir_db (
    .clk   (clk),
    .reset (reset),
    .raw   (dir_raw),
    .level (dir_db)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      inc         <= 1'b0;
      up_down_sel <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      inc         <= inc_nxt;
      up_down_sel <= uds_nxt;
    end
  end

  // Direction only tracks the switch in IDLE, so a held press keeps the direction it started with.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    inc_nxt   = 1'b0;
    uds_nxt   = up_down_sel;
    case (state)
      IDLE: begin
        uds_nxt = dir_db;
        if (btn_db) begin
          inc_nxt   = 1'b1;
          timer_nxt = '0;
          state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (!btn_db) begin
          state_nxt = IDLE;
        end else if (!repeat_en) begin
          timer_nxt = '0;
        end else if (timer == DELAY_LIM) begin
          inc_nxt   = 1'b1;
          timer_nxt = '0;
          state_nxt = REPEAT;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      REPEAT: begin
        // Release is checked first so it beats a coincident timer expiry.
        if (!btn_db) begin
          state_nxt = IDLE;
        end else if (!repeat_en) begin
          timer_nxt = '0;
          state_nxt = DELAY;
        end else if (timer == PERIOD_LIM) begin
          inc_nxt   = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_PERIOD=2.
module tb_pulse_conditioner;

  logic clk;
  logic reset;
  logic btn_raw;
  logic dir_raw;
  logic repeat_en;
  logic inc;
  logic up_down_sel;
  logic btn_db;

  int n_checks;
  int n_fail;
  int cyc;
  int dbl_pulse;
  logic prev_inc;
  int pulses[$];
  logic db_hist  [0:255];
  logic uds_hist [0:255];

  pulse_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (3),
    .REPEAT_PERIOD   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .dir_raw     (dir_raw),
    .repeat_en   (repeat_en),
    .inc         (inc),
    .up_down_sel (up_down_sel),
    .btn_db      (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock; sampled 1 time unit after the rising edge. cyc numbers the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (inc) pulses.push_back(cyc);
    if (inc && prev_inc) dbl_pulse++;
    prev_inc = inc;
    if (cyc < 256) begin
      db_hist[cyc]  = btn_db;
      uds_hist[cyc] = up_down_sel;
    end
  endtask

  task automatic begin_scn();
    cyc = 0;
    pulses.delete();
  endtask

  function automatic int pulse_at(input int i);
    return (pulses.size() > i) ? pulses[i] : 0;
  endfunction

  int exp3 [9] = '{7, 10, 12, 14, 16, 18, 20, 22, 24};
  logic [4:0] bounce;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    dbl_pulse = 0;
    prev_inc  = 1'b0;
    cyc       = 0;
    btn_raw   = 1'b0;
    dir_raw   = 1'b0;
    repeat_en = 1'b0;
    reset     = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_inc", inc, 0);
    check("rst_uds", up_down_sel, 0);
    check("rst_btn_db", btn_db, 0);
    repeat (3) step();
    reset = 1'b1;
    repeat (5) step();

    // Single press, no repeat: one pulse at edge 7, debounced release 6 edges after last high sample.
    begin_scn();
    repeat_en = 1'b0;
    btn_raw   = 1'b1;
    repeat (50) step();
    btn_raw = 1'b0;
    repeat (15) step();
    check("s1_db_e5", db_hist[5], 0);
    check("s1_db_e6", db_hist[6], 1);
    check("s1_npulse", pulses.size(), 1);
    check("s1_pulse_edge", pulse_at(0), 7);
    check("s1_db_e55", db_hist[55], 1);
    check("s1_db_e56", db_hist[56], 0);

    // Bounce 1,0,1,0 then steady 1 from edge 5: single pulse at edge 11.
    begin_scn();
    bounce = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      btn_raw = bounce[i];
      step();
    end
    repeat (30) step();
    btn_raw = 1'b0;
    repeat (15) step();
    check("s2_db_e9", db_hist[9], 0);
    check("s2_db_e10", db_hist[10], 1);
    check("s2_npulse", pulses.size(), 1);
    check("s2_pulse_edge", pulse_at(0), 11);

    // Auto-repeat; release lands on a period expiry at edge 26, which must not pulse.
    begin_scn();
    repeat_en = 1'b1;
    btn_raw   = 1'b1;
    repeat (19) step();
    btn_raw = 1'b0;
    repeat (20) step();
    check("s3_npulse", pulses.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("s3_pulse%0d", i), pulse_at(i), exp3[i]);
    check("s3_db_e24", db_hist[24], 1);
    check("s3_db_e25", db_hist[25], 0);

    // Direction freeze: switch flips to 0 mid-hold, output follows only after return to IDLE.
    dir_raw   = 1'b1;
    repeat_en = 1'b0;
    repeat (12) step();
    check("s5_uds_idle", up_down_sel, 1);
    begin_scn();
    repeat_en = 1'b1;
    btn_raw   = 1'b1;
    repeat (10) step();
    dir_raw = 1'b0;
    repeat (19) step();
    btn_raw = 1'b0;
    repeat (15) step();
    check("s5_npulse", pulses.size(), 14);
    check("s5_last_pulse", pulse_at(13), 34);
    check("s5_uds_e7", uds_hist[7], 1);
    check("s5_uds_e20", uds_hist[20], 1);
    check("s5_uds_e36", uds_hist[36], 1);
    check("s5_uds_e37", uds_hist[37], 0);

    // Async reset in the middle of a repeat pulse, button kept held.
    dir_raw   = 1'b1;
    repeat_en = 1'b1;
    repeat (12) step();
    begin_scn();
    btn_raw = 1'b1;
    repeat (10) step();
    check("s6_inc_pre_rst", inc, 1);
    check("s6_uds_pre_rst", up_down_sel, 1);
    reset = 1'b0;
    #1;
    check("s6_rst_inc", inc, 0);
    check("s6_rst_uds", up_down_sel, 0);
    check("s6_rst_btn_db", btn_db, 0);
    repeat (2) step();
    check("s6_inc_in_rst", inc, 0);
    reset = 1'b1;
    begin_scn();
    repeat (12) step();
    check("s6_npulse", pulses.size(), 3);
    check("s6_first_pulse", pulse_at(0), 7);
    check("s6_second_pulse", pulse_at(1), 10);
    check("s6_uds_e6", uds_hist[6], 0);
    check("s6_uds_e7", uds_hist[7], 1);
    btn_raw = 1'b0;
    repeat (15) step();

    check("inc_single_cycle", dbl_pulse, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
